// File: rtl/wb_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_sched_pkg
//  Description : Shared constants for the write-back scheduler: layer codes,
//                per-layer BRAM32k base addresses, FSM state encoding and the
//                default flush length.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_sched_pkg;

   // Default number of cycles FinishWB stays high
   localparam int FLUSH_CYC_DEF = 10;

   // Layer codes presented by the top-level layer FSM
   localparam logic [3:0] Layer1 = 4'd1;
   localparam logic [3:0] Layer2 = 4'd2;
   localparam logic [3:0] Layer3 = 4'd3;
   localparam logic [3:0] Layer4 = 4'd4;
   localparam logic [3:0] Layer5 = 4'd5;

   // Per-layer base addresses for BRAM32k port 1 (A) and port 2 (B)
   localparam logic [11:0] BASE_A_L1 = 12'h000;
   localparam logic [11:0] BASE_B_L1 = 12'h800;
   localparam logic [11:0] BASE_A_L2 = 12'h100;
   localparam logic [11:0] BASE_B_L2 = 12'h900;
   localparam logic [11:0] BASE_A_L3 = 12'h200;
   localparam logic [11:0] BASE_B_L3 = 12'hA00;
   localparam logic [11:0] BASE_A_L4 = 12'h400;
   localparam logic [11:0] BASE_B_L4 = 12'hC00;
   localparam logic [11:0] BASE_A_L5 = 12'hFFE;
   localparam logic [11:0] BASE_B_L5 = 12'h7FE;

   // Scheduler state encoding
   typedef enum logic [1:0] {
      WBS_IDLE  = 2'd0,
      WBS_RUN   = 2'd1,
      WBS_FLUSH = 2'd2,
      WBS_DONE  = 2'd3
   } wbs_state_t;

   // Port-1 base address for a layer; unknown codes map to address 0
   function automatic logic [11:0] base_a(input logic [3:0] layer);
      case (layer)
         Layer1:  base_a = BASE_A_L1;
         Layer2:  base_a = BASE_A_L2;
         Layer3:  base_a = BASE_A_L3;
         Layer4:  base_a = BASE_A_L4;
         Layer5:  base_a = BASE_A_L5;
         default: base_a = 12'h000;
      endcase
   endfunction

   // Port-2 base address for a layer; unknown codes map to address 0
   function automatic logic [11:0] base_b(input logic [3:0] layer);
      case (layer)
         Layer1:  base_b = BASE_B_L1;
         Layer2:  base_b = BASE_B_L2;
         Layer3:  base_b = BASE_B_L3;
         Layer4:  base_b = BASE_B_L4;
         Layer5:  base_b = BASE_B_L5;
         default: base_b = 12'h000;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_sched_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : wb_addr_gen
//  Description : Holds the latched base addresses, word count and running
//                word index; produces both BRAM32k port addresses and the
//                last-word flag.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_addr_gen
   import wb_sched_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 12
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_base_a,
   input  logic [ADDR_W-1:0] load_base_b,
   input  logic [CNT_W-1:0]  load_num,
   input  logic              inc,
   output logic [ADDR_W-1:0] addr_1,
   output logic [ADDR_W-1:0] addr_2,
   output logic              last_word
);

   logic [ADDR_W-1:0] base_a_q, base_a_d;
   logic [ADDR_W-1:0] base_b_q, base_b_d;
   logic [CNT_W-1:0]  num_q,    num_d;
   logic [CNT_W-1:0]  idx_q,    idx_d;

   // Latch layer parameters on load, otherwise advance the index per write
   always_comb begin
      base_a_d = base_a_q;
      base_b_d = base_b_q;
      num_d    = num_q;
      idx_d    = idx_q;
      if (load) begin
         base_a_d = load_base_a;
         base_b_d = load_base_b;
         num_d    = load_num;
         idx_d    = '0;
      end else if (inc) begin
         idx_d = idx_q + CNT_W'(1);
      end
   end

   // Register bank for the address generator
   always_ff @(posedge clk) begin
      if (rst) begin
         base_a_q <= '0;
         base_b_q <= '0;
         num_q    <= '0;
         idx_q    <= '0;
      end else begin
         base_a_q <= base_a_d;
         base_b_q <= base_b_d;
         num_q    <= num_d;
         idx_q    <= idx_d;
      end
   end

   // Sums wrap naturally at the address width
   assign addr_1    = base_a_q + ADDR_W'(idx_q);
   assign addr_2    = base_b_q + ADDR_W'(idx_q);
   assign last_word = (idx_q == (num_q - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/wb_sched.sv
`default_nettype none
// ============================================================================
//  Module      : wb_sched
//  Description : Write-back scheduler for the BRAM32k output buffer. Gates the
//                writeback stage, generates word addresses from per-layer
//                bases, drives the FinishWB flush window and arbitrates the
//                BRAM32k write port between writeback (priority) and loader.
//                Optional macro WB_SCHED_PERF_EN adds perf_stall / perf_drop
//                saturating counters.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_sched
   import wb_sched_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 64,
   parameter int CNT_W     = 12,
   parameter int FLUSH_CYC = FLUSH_CYC_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        Layer,
   input  logic [CNT_W-1:0]  num_words,
   input  logic              pe_valid,
   output logic              wb_en,
   output logic              FinishWB,
   input  logic              wb_we,
   input  logic [DATA_W-1:0] wb_din1,
   input  logic [DATA_W-1:0] wb_din2,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_din,
   output logic              ld_gnt,
   output logic              we_BRAM32k,
   output logic [ADDR_W-1:0] addr_BRAM32k_1,
   output logic [ADDR_W-1:0] addr_BRAM32k_2,
   output logic [DATA_W-1:0] din_BRAM32k_1,
   output logic [DATA_W-1:0] din_BRAM32k_2,
   output logic              busy,
   output logic              done
`ifdef WB_SCHED_PERF_EN
   ,
   output logic [15:0]       perf_stall,
   output logic [7:0]        perf_drop
`endif
);

   localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   wbs_state_t        state_q, state_d;
   logic [FC_W-1:0]   fcnt_q, fcnt_d;
   logic              extra_q, extra_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr1_q, addr1_d;
   logic [ADDR_W-1:0] addr2_q, addr2_d;
   logic [DATA_W-1:0] din1_q, din1_d;
   logic [DATA_W-1:0] din2_q, din2_d;
   logic              done_q, done_d;

   logic              start_acc;
   logic              wb_window;
   logic              wb_acc;
   logic              last_word;
   logic [ADDR_W-1:0] gen_addr_1;
   logic [ADDR_W-1:0] gen_addr_2;

   // Writeback owns the port whenever it strobes in RUN/FLUSH, even if the
   // strobe itself is then dropped (second trailing word in FLUSH)
   assign start_acc = start & (state_q == WBS_IDLE);
   assign wb_window = (state_q == WBS_RUN) | (state_q == WBS_FLUSH);
   assign wb_acc    = wb_we & ((state_q == WBS_RUN) |
                               ((state_q == WBS_FLUSH) & ~extra_q));
   assign ld_gnt    = ld_req & ~(wb_we & wb_window);

   assign wb_en     = (state_q == WBS_RUN) & pe_valid;
   assign FinishWB  = (state_q == WBS_FLUSH);
   assign busy      = (state_q != WBS_IDLE);
   assign done      = done_q;

   assign we_BRAM32k     = we_q;
   assign addr_BRAM32k_1 = addr1_q;
   assign addr_BRAM32k_2 = addr2_q;
   assign din_BRAM32k_1  = din1_q;
   assign din_BRAM32k_2  = din2_q;

   wb_addr_gen #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_addr_gen (
      .clk         (clk),
      .rst         (rst),
      .load        (start_acc),
      .load_base_a (ADDR_W'(base_a(Layer))),
      .load_base_b (ADDR_W'(base_b(Layer))),
      .load_num    (num_words),
      .inc         (wb_acc),
      .addr_1      (gen_addr_1),
      .addr_2      (gen_addr_2),
      .last_word   (last_word)
   );

   // Next-state logic: layer sequencing and flush window timing
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      extra_d = extra_q;
      case (state_q)
         WBS_IDLE: begin
            if (start) begin
               fcnt_d  = '0;
               extra_d = 1'b0;
               state_d = (num_words == '0) ? WBS_DONE : WBS_RUN;
            end
         end
         WBS_RUN: begin
            if (wb_we && last_word) begin
               fcnt_d  = '0;
               extra_d = 1'b0;
               state_d = WBS_FLUSH;
            end
         end
         WBS_FLUSH: begin
            if (wb_acc) begin
               extra_d = 1'b1;
            end
            if (fcnt_q == FC_W'(FLUSH_CYC - 1)) begin
               state_d = WBS_DONE;
            end else begin
               fcnt_d = fcnt_q + FC_W'(1);
            end
         end
         WBS_DONE: begin
            state_d = WBS_IDLE;
         end
         default: begin
            state_d = WBS_IDLE;
         end
      endcase
   end

   // Next values of the registered BRAM32k port: writeback first, loader second
   always_comb begin
      we_d    = 1'b0;
      addr1_d = addr1_q;
      addr2_d = addr2_q;
      din1_d  = din1_q;
      din2_d  = din2_q;
      done_d  = (state_q == WBS_DONE);
      if (wb_acc) begin
         we_d    = 1'b1;
         addr1_d = gen_addr_1;
         addr2_d = gen_addr_2;
         din1_d  = wb_din1;
         din2_d  = wb_din2;
      end else if (ld_gnt) begin
         we_d    = 1'b1;
         addr1_d = ld_addr;
         din1_d  = ld_din;
      end
   end

   // State and output registers; reset discards any in-flight write
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WBS_IDLE;
         fcnt_q  <= '0;
         extra_q <= 1'b0;
         we_q    <= 1'b0;
         addr1_q <= '0;
         addr2_q <= '0;
         din1_q  <= '0;
         din2_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         extra_q <= extra_d;
         we_q    <= we_d;
         addr1_q <= addr1_d;
         addr2_q <= addr2_d;
         din1_q  <= din1_d;
         din2_q  <= din2_d;
         done_q  <= done_d;
      end
   end

`ifdef WB_SCHED_PERF_EN
   logic [15:0] stall_q, stall_d;
   logic [7:0]  drop_q,  drop_d;

   // Saturating counters of loader stalls and dropped writeback strobes
   always_comb begin
      stall_d = stall_q;
      drop_d  = drop_q;
      if (start_acc) begin
         stall_d = '0;
         drop_d  = '0;
      end else begin
         if (ld_req && !ld_gnt && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
         end
         if (wb_we && !wb_acc && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
         end
      end
   end

   // Perf counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         drop_q  <= '0;
      end else begin
         stall_q <= stall_d;
         drop_q  <= drop_d;
      end
   end

   assign perf_stall = stall_q;
   assign perf_drop  = drop_q;
`endif

endmodule
`default_nettype wire
